// File: rtl/sprite_read_arbiter.sv
// Round-robin arbiter sharing one fixed-latency sprite ROM reader among N_REQ requesters.
// Latency: gnt same cycle as req, rd_x/rd_y next cycle, response 1+READ_LATENCY cycles after grant.
// Backpressure: none; one grant and one response per cycle, requesters hold req until granted.
module sprite_read_arbiter #(
    parameter int N_REQ        = 4,
    parameter int WIDTH        = 52,
    parameter int HEIGHT       = 52,
    parameter int READ_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*10-1:0]      req_x,
    input  logic [N_REQ*9-1:0]       req_y,
    output logic [N_REQ-1:0]         gnt,
    output logic [9:0]               rd_x,
    output logic [8:0]               rd_y,
    input  logic [15:0]              rd_pixel,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [15:0]              rsp_pixel,
    output logic                     rsp_oob
);
    localparam int IDW   = $clog2(N_REQ);
    localparam int DEPTH = 1 + READ_LATENCY;

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
        logic           oob;
    } tag_t;

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [9:0]     rd_x_q, rd_x_d;
    logic [8:0]     rd_y_q, rd_y_d;
    tag_t           tag_q [DEPTH];
    tag_t           tag_d [DEPTH];
    tag_t           last;

    logic           win_vld;
    logic [IDW-1:0] win_id;
    logic [9:0]     win_x;
    logic [8:0]     win_y;
    logic           win_oob;

    // Scan requesters starting at ptr, wrapping, first asserted req wins.
    always_comb begin
        int             idx;
        logic [IDW-1:0] cand;
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            cand = IDW'(idx);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

    always_comb begin
        win_x = '0;
        win_y = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win_id == IDW'(k)) begin
                win_x = req_x[k*10 +: 10];
                win_y = req_y[k*9 +: 9];
            end
        end
        win_oob = (int'(win_x) >= WIDTH) || (int'(win_y) >= HEIGHT);
    end

    always_comb begin
        ptr_d  = ptr_q;
        rd_x_d = rd_x_q;
        rd_y_d = rd_y_q;
        tag_d[0] = '0;
        for (int s = 1; s < DEPTH; s++) tag_d[s] = tag_q[s-1];
        if (win_vld) begin
            ptr_d  = (int'(win_id) == N_REQ - 1) ? '0 : win_id + IDW'(1);
            // Out-of-bounds reads park the ROM address at the origin.
            rd_x_d = win_oob ? '0 : win_x;
            rd_y_d = win_oob ? '0 : win_y;
            tag_d[0].vld = 1'b1;
            tag_d[0].id  = win_id;
            tag_d[0].oob = win_oob;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            rd_x_q <= '0;
            rd_y_q <= '0;
            for (int s = 0; s < DEPTH; s++) tag_q[s] <= '0;
        end else begin
            ptr_q  <= ptr_d;
            rd_x_q <= rd_x_d;
            rd_y_q <= rd_y_d;
            for (int s = 0; s < DEPTH; s++) tag_q[s] <= tag_d[s];
        end
    end

    assign last = tag_q[DEPTH-1];

    always_comb begin
        gnt = '0;
        if (rst_n && win_vld) gnt[win_id] = 1'b1;
        rsp_valid = '0;
        if (last.vld) rsp_valid[last.id] = 1'b1;
    end

    assign rsp_id    = last.vld ? last.id : '0;
    assign rsp_oob   = last.vld & last.oob;
    assign rsp_pixel = (last.vld && !last.oob) ? rd_pixel : 16'h0000;
    assign rd_x      = rd_x_q;
    assign rd_y      = rd_y_q;
endmodule

// File: tb/tb_sprite_read_arbiter.sv
// Randomized bench for sprite_read_arbiter against a queue-based grant/response model.
module tb_sprite_read_arbiter;
    localparam int N   = 4;
    localparam int IDW = $clog2(N);
    localparam int W   = 52;
    localparam int H   = 52;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N*10-1:0]  req_x;
    logic [N*9-1:0]   req_y;
    logic [N-1:0]     gnt;
    logic [9:0]       rd_x;
    logic [8:0]       rd_y;
    logic [15:0]      rd_pixel;
    logic [N-1:0]     rsp_valid;
    logic [IDW-1:0]   rsp_id;
    logic [15:0]      rsp_pixel;
    logic             rsp_oob;

    sprite_read_arbiter #(.N_REQ(N), .WIDTH(W), .HEIGHT(H), .READ_LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_x(req_x), .req_y(req_y), .gnt(gnt),
        .rd_x(rd_x), .rd_y(rd_y), .rd_pixel(rd_pixel), .rsp_valid(rsp_valid),
        .rsp_id(rsp_id), .rsp_pixel(rsp_pixel), .rsp_oob(rsp_oob)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom(input int a);
        logic [31:0] t;
        t = a * 32'd40503;
        return t[15:0] ^ t[31:16] ^ 16'h5A5A;
    endfunction

    // Image reader: fixed two-cycle read latency.
    logic [15:0] p1, p2;
    always_ff @(posedge clk) begin
        p1 <= rom(int'(rd_y) * W + int'(rd_x));
        p2 <= p1;
    end
    assign rd_pixel = p2;

    typedef struct packed {
        logic [31:0]    due;
        logic [IDW-1:0] id;
        logic           oob;
        logic [9:0]     x;
        logic [8:0]     y;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   mptr = 0;
    logic [9:0]      mrdx = '0;
    logic [8:0]      mrdy = '0;
    logic [N*10-1:0] vx = '0;
    logic [N*9-1:0]  vy = '0;

    logic [N-1:0]   e_gnt, e_vld;
    logic [IDW-1:0] e_id;
    logic           e_oob;
    logic [15:0]    e_pix;
    logic [9:0]     e_rdx;
    logic [8:0]     e_rdy;

    task automatic new_coord(input int i, input bit allow_oob);
        int x, y;
        x = $urandom_range(0, W - 1);
        y = $urandom_range(0, H - 1);
        if (allow_oob && $urandom_range(0, 9) == 0) begin
            if ($urandom_range(0, 1) == 1) x = $urandom_range(W, 1023);
            else y = $urandom_range(H, 511);
        end
        vx[i*10 +: 10] = 10'(x);
        vy[i*9 +: 9]   = 9'(y);
    endtask

    // Advance one cycle, apply inputs, then compute the expected outputs for this cycle.
    task automatic step(input logic rst, input logic [N-1:0] r);
        exp_t h;
        bit   found;
        @(posedge clk);
        cyc++;
        #1;
        rst_n = rst;
        req   = r;
        req_x = vx;
        req_y = vy;
        #1;
        e_gnt = '0; e_vld = '0; e_id = '0; e_oob = 1'b0; e_pix = '0;
        if (!rst) begin
            q.delete();
            mptr = 0; mrdx = '0; mrdy = '0; e_rdx = '0; e_rdy = '0;
        end else begin
            e_rdx = mrdx;
            e_rdy = mrdy;
            if (q.size() > 0 && int'(q[0].due) == cyc) begin
                h = q.pop_front();
                e_vld[h.id] = 1'b1;
                e_id  = h.id;
                e_oob = h.oob;
                e_pix = h.oob ? 16'h0000 : rom(int'(h.y) * W + int'(h.x));
            end
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                int i = (mptr + k) % N;
                if (!found && r[i]) begin
                    found = 1'b1;
                    e_gnt[i] = 1'b1;
                    h.due = 32'(cyc + 3);
                    h.id  = IDW'(i);
                    h.x   = vx[i*10 +: 10];
                    h.y   = vy[i*9 +: 9];
                    h.oob = (int'(h.x) >= W) || (int'(h.y) >= H);
                    q.push_back(h);
                    mptr = (i + 1) % N;
                    mrdx = h.oob ? 10'd0 : h.x;
                    mrdy = h.oob ? 9'd0 : h.y;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req   = '1;
        for (int i = 0; i < N; i++) new_coord(i, 0);
        req_x = vx;
        req_y = vy;
        #2;
        if ({gnt, rd_x, rd_y, rsp_valid, rsp_id, rsp_pixel, rsp_oob} !== '0) begin
            errors++;
            $display("FAIL reset_state got gnt=%b rd=(%0d,%0d) vld=%b id=%0d pix=%h oob=%b required all zero",
                     gnt, rd_x, rd_y, rsp_valid, rsp_id, rsp_pixel, rsp_oob);
        end
        checks++;
        for (int c = 0; c < 3; c++) begin
            step(1'b0, '1);
            if ({gnt, rd_x, rd_y, rsp_valid, rsp_id, rsp_oob, rsp_pixel} !== '0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got gnt=%b rd=(%0d,%0d) vld=%b pix=%h required all zero",
                         cyc, gnt, rd_x, rd_y, rsp_valid, rsp_pixel);
            end
            checks++;
        end
    endtask

    task automatic test_round_robin;
        step(1'b0, '0);
        for (int c = 0; c < 20; c++) begin
            step(1'b1, (c < 16) ? '1 : '0);
            if ({gnt, rd_x, rd_y} !== {e_gnt, e_rdx, e_rdy}) begin
                errors++;
                $display("FAIL rr_req cyc=%0d got gnt=%b rd=(%0d,%0d) exp gnt=%b rd=(%0d,%0d)", cyc, gnt, rd_x, rd_y, e_gnt, e_rdx, e_rdy);
            end
            checks++;
            if ({rsp_valid, rsp_id, rsp_oob, rsp_pixel} !== {e_vld, e_id, e_oob, e_pix}) begin
                errors++;
                $display("FAIL rr_rsp cyc=%0d got vld=%b id=%0d oob=%b pix=%h exp vld=%b id=%0d oob=%b pix=%h", cyc, rsp_valid, rsp_id, rsp_oob, rsp_pixel, e_vld, e_id, e_oob, e_pix);
            end
            checks++;
            if (c < 16) begin
                if (gnt !== (N'(1) << (c % N))) begin
                    errors++;
                    $display("FAIL rr_order c=%0d got gnt=%b exp %b", c, gnt, N'(1) << (c % N));
                end
                checks++;
            end
            if (c >= 3 && c < 19) begin
                if ($countones(rsp_valid) != 1) begin
                    errors++;
                    $display("FAIL rr_throughput c=%0d got vld=%b exp one-hot", c, rsp_valid);
                end
                checks++;
            end
            for (int i = 0; i < N; i++) if (e_gnt[i]) new_coord(i, 0);
        end
    endtask

    task automatic test_single;
        logic [N-1:0] r;
        vx[2*10 +: 10] = 10'd10;
        vy[2*9 +: 9]   = 9'd20;
        for (int c = 0; c < 6; c++) begin
            r = '0;
            if (c == 0) r[2] = 1'b1;
            step(1'b1, r);
            if ({gnt, rd_x, rd_y} !== {e_gnt, e_rdx, e_rdy}) begin
                errors++;
                $display("FAIL single_req cyc=%0d got gnt=%b rd=(%0d,%0d) exp gnt=%b rd=(%0d,%0d)", cyc, gnt, rd_x, rd_y, e_gnt, e_rdx, e_rdy);
            end
            checks++;
            if ({rsp_valid, rsp_id, rsp_oob, rsp_pixel} !== {e_vld, e_id, e_oob, e_pix}) begin
                errors++;
                $display("FAIL single_rsp cyc=%0d got vld=%b id=%0d oob=%b pix=%h exp vld=%b id=%0d oob=%b pix=%h", cyc, rsp_valid, rsp_id, rsp_oob, rsp_pixel, e_vld, e_id, e_oob, e_pix);
            end
            checks++;
            if (c == 0) begin
                if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b exp 0100", gnt); end
                checks++;
            end
            if (c == 1) begin
                if (rd_x !== 10'd10 || rd_y !== 9'd20) begin
                    errors++; $display("FAIL single_rd got (%0d,%0d) exp (10,20)", rd_x, rd_y);
                end
                checks++;
            end
            if (c == 3) begin
                if (rsp_valid !== 4'b0100 || rsp_id !== 2'd2 || rsp_pixel !== rom(20 * W + 10)) begin
                    errors++;
                    $display("FAIL single_pixel got vld=%b id=%0d pix=%h exp vld=0100 id=2 pix=%h", rsp_valid, rsp_id, rsp_pixel, rom(20 * W + 10));
                end
                checks++;
            end
        end
    endtask

    task automatic test_fairness;
        logic [N-1:0] r;
        int  first = -1;
        bit  prev0 = 1'b0;
        for (int i = 0; i < N; i++) new_coord(i, 0);
        for (int c = 0; c < 24; c++) begin
            r = '0;
            if (c < 20) r[0] = 1'b1;
            if (c >= 10 && c < 20) r[3] = 1'b1;
            step(1'b1, r);
            if ({gnt, rd_x, rd_y} !== {e_gnt, e_rdx, e_rdy}) begin
                errors++;
                $display("FAIL fair_req cyc=%0d got gnt=%b rd=(%0d,%0d) exp gnt=%b rd=(%0d,%0d)", cyc, gnt, rd_x, rd_y, e_gnt, e_rdx, e_rdy);
            end
            checks++;
            if ({rsp_valid, rsp_id, rsp_oob, rsp_pixel} !== {e_vld, e_id, e_oob, e_pix}) begin
                errors++;
                $display("FAIL fair_rsp cyc=%0d got vld=%b id=%0d oob=%b pix=%h exp vld=%b id=%0d oob=%b pix=%h", cyc, rsp_valid, rsp_id, rsp_oob, rsp_pixel, e_vld, e_id, e_oob, e_pix);
            end
            checks++;
            if (c >= 10 && c < 20) begin
                if (first < 0 && gnt[3]) first = c;
                if (gnt[0] && prev0) begin
                    errors++;
                    $display("FAIL fair_repeat c=%0d got req0 granted twice in a row exp alternation", c);
                end
                checks++;
                prev0 = gnt[0];
            end
            for (int i = 0; i < N; i++) if (e_gnt[i]) new_coord(i, 0);
        end
        if (first < 0 || first - 10 > 3) begin
            errors++;
            $display("FAIL fair_latency got first grant at c=%0d exp within 10..13", first);
        end
        checks++;
    endtask

    task automatic test_oob;
        logic [N-1:0] r;
        vx[0 +: 10]  = 10'd7;  vy[0 +: 9]  = 9'd9;
        vx[10 +: 10] = 10'd52; vy[9 +: 9]  = 9'd0;
        vx[20 +: 10] = 10'd0;  vy[18 +: 9] = 9'd60;
        vx[30 +: 10] = 10'd51; vy[27 +: 9] = 9'd51;
        for (int c = 0; c < 8; c++) begin
            r = '0;
            if (c < 4) r[c] = 1'b1;
            step(1'b1, r);
            if ({gnt, rd_x, rd_y} !== {e_gnt, e_rdx, e_rdy}) begin
                errors++;
                $display("FAIL oob_req cyc=%0d got gnt=%b rd=(%0d,%0d) exp gnt=%b rd=(%0d,%0d)", cyc, gnt, rd_x, rd_y, e_gnt, e_rdx, e_rdy);
            end
            checks++;
            if ({rsp_valid, rsp_id, rsp_oob, rsp_pixel} !== {e_vld, e_id, e_oob, e_pix}) begin
                errors++;
                $display("FAIL oob_rsp cyc=%0d got vld=%b id=%0d oob=%b pix=%h exp vld=%b id=%0d oob=%b pix=%h", cyc, rsp_valid, rsp_id, rsp_oob, rsp_pixel, e_vld, e_id, e_oob, e_pix);
            end
            checks++;
            if (c == 2 || c == 3) begin
                if (rd_x !== 10'd0 || rd_y !== 9'd0) begin
                    errors++; $display("FAIL oob_rd_zero c=%0d got (%0d,%0d) exp (0,0)", c, rd_x, rd_y);
                end
                checks++;
            end
            if (c == 4 || c == 5) begin
                if (rsp_oob !== 1'b1 || rsp_pixel !== 16'h0000 || rsp_valid !== (N'(1) << (c - 3))) begin
                    errors++;
                    $display("FAIL oob_rsp_flag c=%0d got vld=%b oob=%b pix=%h exp vld=%b oob=1 pix=0000", c, rsp_valid, rsp_oob, rsp_pixel, N'(1) << (c - 3));
                end
                checks++;
            end
            if (c == 6) begin
                if (rsp_oob !== 1'b0 || rsp_valid !== 4'b1000 || rsp_pixel !== rom(51 * W + 51)) begin
                    errors++;
                    $display("FAIL oob_edge_inbounds got vld=%b oob=%b pix=%h exp vld=1000 oob=0 pix=%h", rsp_valid, rsp_oob, rsp_pixel, rom(51 * W + 51));
                end
                checks++;
            end
        end
    endtask

    task automatic test_reset_midflight;
        logic [N-1:0] r;
        logic         rst;
        for (int i = 0; i < N; i++) new_coord(i, 0);
        for (int c = 0; c < 15; c++) begin
            r   = '0;
            rst = (c != 6);
            if (c == 4) r[0] = 1'b1;
            if (c == 5) r[1] = 1'b1;
            if (c == 9) begin r[1] = 1'b1; r[2] = 1'b1; end
            if (c == 10) r[2] = 1'b1;
            step(rst, r);
            if ({gnt, rd_x, rd_y} !== {e_gnt, e_rdx, e_rdy}) begin
                errors++;
                $display("FAIL midrst_req cyc=%0d got gnt=%b rd=(%0d,%0d) exp gnt=%b rd=(%0d,%0d)", cyc, gnt, rd_x, rd_y, e_gnt, e_rdx, e_rdy);
            end
            checks++;
            if ({rsp_valid, rsp_id, rsp_oob, rsp_pixel} !== {e_vld, e_id, e_oob, e_pix}) begin
                errors++;
                $display("FAIL midrst_rsp cyc=%0d got vld=%b id=%0d oob=%b pix=%h exp vld=%b id=%0d oob=%b pix=%h", cyc, rsp_valid, rsp_id, rsp_oob, rsp_pixel, e_vld, e_id, e_oob, e_pix);
            end
            checks++;
            if (c == 7 || c == 8) begin
                if (rsp_valid !== '0) begin
                    errors++; $display("FAIL midrst_dropped c=%0d got vld=%b exp 0000", c, rsp_valid);
                end
                checks++;
            end
            if (c == 9) begin
                if (gnt !== 4'b0010) begin
                    errors++; $display("FAIL midrst_ptr got gnt=%b exp 0010", gnt);
                end
                checks++;
            end
        end
    endtask

    task automatic test_idle_gaps;
        logic [N-1:0] r;
        logic         hist [0:31];
        for (int c = 0; c < 28; c++) begin
            r = '0;
            if (c < 24 && (c % 2) == 0) r[$urandom_range(0, N - 1)] = 1'b1;
            step(1'b1, r);
            if ({gnt, rd_x, rd_y} !== {e_gnt, e_rdx, e_rdy}) begin
                errors++;
                $display("FAIL idle_req cyc=%0d got gnt=%b rd=(%0d,%0d) exp gnt=%b rd=(%0d,%0d)", cyc, gnt, rd_x, rd_y, e_gnt, e_rdx, e_rdy);
            end
            checks++;
            if ({rsp_valid, rsp_id, rsp_oob, rsp_pixel} !== {e_vld, e_id, e_oob, e_pix}) begin
                errors++;
                $display("FAIL idle_rsp cyc=%0d got vld=%b id=%0d oob=%b pix=%h exp vld=%b id=%0d oob=%b pix=%h", cyc, rsp_valid, rsp_id, rsp_oob, rsp_pixel, e_vld, e_id, e_oob, e_pix);
            end
            checks++;
            hist[c] = |gnt;
            if (c >= 3) begin
                if ((|rsp_valid) !== hist[c-3]) begin
                    errors++; $display("FAIL idle_mirror c=%0d got rsp=%b exp %b", c, |rsp_valid, hist[c-3]);
                end
                checks++;
                if (!(|rsp_valid)) begin
                    if (rsp_pixel !== 16'h0000) begin
                        errors++; $display("FAIL idle_bubble_pix c=%0d got %h exp 0000", c, rsp_pixel);
                    end
                    checks++;
                end
            end
            for (int i = 0; i < N; i++) if (e_gnt[i]) new_coord(i, 0);
        end
    endtask

    task automatic test_random;
        logic [N-1:0] pend = '0;
        for (int c = 0; c < 410; c++) begin
            if (c < 400) begin
                for (int i = 0; i < N; i++) begin
                    if (!pend[i] && $urandom_range(0, 2) == 0) begin
                        pend[i] = 1'b1;
                        new_coord(i, 1);
                    end
                end
            end
            step(1'b1, pend);
            if ({gnt, rd_x, rd_y} !== {e_gnt, e_rdx, e_rdy}) begin
                errors++;
                $display("FAIL rand_req cyc=%0d got gnt=%b rd=(%0d,%0d) exp gnt=%b rd=(%0d,%0d)", cyc, gnt, rd_x, rd_y, e_gnt, e_rdx, e_rdy);
            end
            checks++;
            if ({rsp_valid, rsp_id, rsp_oob, rsp_pixel} !== {e_vld, e_id, e_oob, e_pix}) begin
                errors++;
                $display("FAIL rand_rsp cyc=%0d got vld=%b id=%0d oob=%b pix=%h exp vld=%b id=%0d oob=%b pix=%h", cyc, rsp_valid, rsp_id, rsp_oob, rsp_pixel, e_vld, e_id, e_oob, e_pix);
            end
            checks++;
            pend = pend & ~e_gnt;
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_fairness();
        test_oob();
        test_reset_midflight();
        test_idle_gaps();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
